// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//
// arb_state_t : 2-bit encoding of the arbiter FSM states.
// NOP_INSTR   : canonical RV32I NOP (addi x0, x0, 0). It is the reset value
//               of the fetch data register, so a fetch stage that samples
//               if_rdata before any fetch has completed decodes a harmless
//               instruction.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_DM_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch (IF)
// and data memory (DM) requesters.
//
// One access is in flight at a time. An access takes at least three cycles:
// IDLE (arbitrate), X_WAIT (memory busy) and RESP (one-cycle ready pulse).
// DM normally has priority. After STARVE_MAX consecutive arbitrations that
// IF lost while requesting, IF wins the next contested arbitration.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   if_req, if_addr          fetch request (held until if_ready)
//   if_rdata, if_ready       fetch data and one-cycle completion pulse
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_wstrb       data request (held until dm_ready)
//   dm_rdata, dm_ready       load data and one-cycle completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb     registered memory command
//   mem_rdata, mem_ack       memory read data and one-cycle completion
//
// The hazard logic derives its stall terms from (if_req & ~if_ready) and
// (dm_req & ~dm_ready); this block drives no stall or flush outputs.
//
// States
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no access in flight; sample requests and arbitrate
//   ST_IF_WAIT | fetch command on the memory port, waiting for mem_ack
//   ST_DM_WAIT | data command on the memory port, waiting for mem_ack
//   ST_RESP    | pulse the granted requester's ready; requests not sampled
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    arb_state_t              state;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    if_wins;

    // IF takes the grant when it is alone, or when it has been passed over
    // STARVE_MAX times in a row while DM is also requesting.
    always_comb begin
        if_wins = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= NOP_INSTR;
            dm_rdata   <= '0;
        end else begin
            // Ready outputs are single-cycle pulses; only the WAIT->RESP
            // transition raises them.
            if_ready <= 1'b0;
            dm_ready <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (if_wins) begin
                        state      <= ST_IF_WAIT;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                        starve_cnt <= '0;
                    end else if (dm_req) begin
                        state     <= ST_DM_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wstrb <= dm_wstrb;
                        // Only a contested loss counts toward starvation.
                        if (if_req && (starve_cnt < STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                // The mem_* command registers are left untouched while
                // waiting, so request changes cannot disturb the access.
                ST_IF_WAIT: begin
                    if (mem_ack) begin
                        state    <= ST_RESP;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                    end
                end

                ST_DM_WAIT: begin
                    if (mem_ack) begin
                        state    <= ST_RESP;
                        mem_req  <= 1'b0;
                        dm_ready <= 1'b1;
                        // A store returns no data; keep the last load value.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end

                // Requests are deliberately ignored here: the requester sees
                // ready in this cycle and updates its request for IDLE.
                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_wstrb = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    riscv_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction timeline plus word-addressed memory image.
    logic [31:0] mem_model [logic [31:0]];
    int          starve;
    bit          busy;
    bit          win_dm;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    int          grant_c;
    int          ack_c;
    int          rdy_c;
    logic [31:0] resp_data;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    bit          if_pend;
    bit          dm_pend;
    bit          if_done;
    bit          dm_done;

    function automatic logic [31:0] read_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic model_reset();
        starve       = 0;
        busy         = 0;
        win_dm       = 0;
        exp_if_rdata = NOP;
        exp_dm_rdata = 32'h0;
        if_pend      = 0;
        dm_pend      = 0;
        if_done      = 0;
        dm_done      = 0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(posedge clk);
        #1;
        chk("rst_mem_req",   32'(mem_req), 32'h0);
        chk("rst_mem_we",    32'(mem_we), 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_if_ready",  32'(if_ready), 32'h0);
        chk("rst_dm_ready",  32'(dm_ready), 32'h0);
        chk("rst_if_rdata",  if_rdata, NOP);
        chk("rst_dm_rdata",  dm_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Cycle c runs from #1 after a rising edge to the next rising edge.
    task automatic run_random(input int n, input int prob, input int maxlat);
        bit          exp_req;
        logic [31:0] w;
        for (int c = 0; c < n; c++) begin
            // Requesters hold until they saw ready in the previous cycle.
            if (if_done) if_pend = 0;
            if (dm_done) dm_pend = 0;
            if (!if_pend && ($urandom_range(0, 99) < prob)) begin
                if_pend = 1;
                if_addr = $urandom & 32'h0000_00FC;
            end
            if (!dm_pend && ($urandom_range(0, 99) < prob)) begin
                dm_pend  = 1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom & 32'h0000_00FC;
                dm_wdata = $urandom;
                dm_wstrb = 4'($urandom_range(0, 15));
            end
            if_req = if_pend;
            dm_req = dm_pend;

            // Arbitration happens in any cycle in which nothing is in flight.
            if ((!busy || c > rdy_c) && (if_pend || dm_pend)) begin
                win_dm = dm_pend && !(if_pend && starve == STARVE_MAX);
                if (win_dm) begin
                    if (if_pend && starve < STARVE_MAX) starve++;
                    m_we    = dm_we;
                    m_addr  = dm_addr;
                    m_wdata = dm_wdata;
                    m_wstrb = dm_wstrb;
                end else begin
                    starve  = 0;
                    m_we    = 0;
                    m_addr  = if_addr;
                    m_wdata = 32'h0;
                    m_wstrb = 4'h0;
                end
                busy    = 1;
                grant_c = c;
                ack_c   = c + 1 + $urandom_range(0, maxlat);
                rdy_c   = ack_c + 1;
            end

            // Memory: real ack at the chosen latency, spurious acks only
            // while no access is waiting.
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (busy && c == ack_c) begin
                mem_ack = 1'b1;
                if (m_we) begin
                    w = read_word(m_addr);
                    for (int b = 0; b < 4; b++) begin
                        if (m_wstrb[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                    end
                    mem_model[m_addr] = w;
                end else begin
                    resp_data = read_word(m_addr);
                    mem_rdata = resp_data;
                end
            end else if (!(busy && c > grant_c && c < ack_c) && ($urandom_range(0, 99) < 25)) begin
                mem_ack = 1'b1;
            end

            @(negedge clk);
            exp_req = busy && c > grant_c && c <= ack_c;
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(m_we));
                if (m_we || !win_dm) chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if_done = busy && c == rdy_c && !win_dm;
            dm_done = busy && c == rdy_c && win_dm;
            if (if_done) exp_if_rdata = resp_data;
            if (dm_done && !m_we) exp_dm_rdata = resp_data;
            chk("if_ready", 32'(if_ready), 32'(if_done));
            chk("dm_ready", 32'(dm_ready), 32'(dm_done));
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("dm_rdata", dm_rdata, exp_dm_rdata);

            @(posedge clk);
            #1;
        end
    endtask

    // Reset mid-DM_WAIT must drop mem_req at once; a late ack is ignored.
    task automatic reset_mid_wait();
        if_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h0000_0100;
        dm_wstrb = 4'h0;
        mem_ack  = 1'b0;
        @(posedge clk);
        #1;
        chk("rw_mem_req_up", 32'(mem_req), 32'h1);
        chk("rw_mem_addr", mem_addr, 32'h0000_0100);
        @(posedge clk);
        #1;
        chk("rw_mem_req_hold", 32'(mem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_async_mem_req", 32'(mem_req), 32'h0);
        chk("rw_async_mem_addr", mem_addr, 32'h0);
        chk("rw_async_dm_ready", 32'(dm_ready), 32'h0);
        chk("rw_async_if_rdata", if_rdata, NOP);
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rw_late_dm_ready", 32'(dm_ready), 32'h0);
            chk("rw_late_if_ready", 32'(if_ready), 32'h0);
            chk("rw_late_mem_req", 32'(mem_req), 32'h0);
            chk("rw_late_dm_rdata", dm_rdata, 32'h0);
            @(posedge clk);
            #1;
        end
        model_reset();
    endtask

    initial begin
        apply_reset();
        run_random(400, 50, 3);
        apply_reset();
        reset_mid_wait();
        run_random(300, 100, 2);
        apply_reset();
        run_random(300, 30, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
